seven_seg_capture: RTL

Decoder-side counterpart of the digit-to-segment encoder: it watches a multiplexed, active-low 7-segment bus (segment pattern plus one-hot digit select), waits for each pattern to settle, and decodes it back to a 4-bit digit per display position. It sits on the display outputs of the Snake top level as an on-chip self-check and score read-back path. It flags any pattern the encoder can never produce.

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seg_pattern_decode.sv | 35 +++
 rtl/seven_seg_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment encodings (active-low, bit 6 = g .. bit 0 = a) and capture FSM states.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_SETTLING,
    ST_COMMIT,
    ST_HELD
  } cap_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Inverse of the digit-to-segment encoder: maps a 7-bit active-low pattern back to a digit.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_blank
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    digit    = 4'hF;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Watches a multiplexed active-low 7-segment bus, waits for each pattern to settle,
// and decodes it back to one digit per display position, flagging impossible patterns.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    pattern_err,
  output logic                    err_sticky
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef struct packed {
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] sel;
  } sample_t;

  sample_t                        sample_q, sample_d, prev_q, prev_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  cap_state_e                     state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]     digits_q, digits_d;
  logic [NUM_DIGITS-1:0]          valid_q, valid_d;
  logic                           update_q, update_d;
  logic                           err_q, err_d;
  logic                           sticky_q, sticky_d;

  logic                           changed, one_hot, multi_hot;
  logic [3:0]                     dec_digit;
  logic                           dec_is_digit, dec_is_blank;

  seg_pattern_decode u_decode (
    .seg      (sample_q.seg),
    .digit    (dec_digit),
    .is_digit (dec_is_digit),
    .is_blank (dec_is_blank)
  );

  always_comb begin
    sample_d  = '{seg: seg_in, sel: digit_sel};
    prev_d    = sample_q;
    changed   = (sample_q != prev_q);
    one_hot   = (sample_q.sel != '0) &&
                ((sample_q.sel & (sample_q.sel - NUM_DIGITS'(1))) == '0);
    multi_hot = (sample_q.sel != '0) && !one_hot;

    if (changed)              cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    else                       cnt_d = cnt_q;

    // A change always restarts the episode; with a threshold of 1 it commits immediately.
    state_d = state_q;
    if (changed) begin
      state_d = (cnt_d == CNT_MAX) ? ST_COMMIT : ST_SETTLING;
    end else begin
      case (state_q)
        ST_SETTLING: if (cnt_d == CNT_MAX) state_d = ST_COMMIT;
        ST_COMMIT:   state_d = ST_HELD;
        ST_HELD:     state_d = ST_HELD;
        default:     state_d = ST_SETTLING;
      endcase
    end

    digits_d = digits_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    if (state_d == ST_COMMIT) begin
      if (one_hot) begin
        if (dec_is_digit || dec_is_blank) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sample_q.sel[i]) begin
              digits_d[i] = dec_digit;
              valid_d[i]  = dec_is_digit;
            end
          end
          update_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (multi_hot) begin
        err_d = 1'b1;
      end
    end
    sticky_d = sticky_q | err_d;
  end

  // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= ST_SETTLING;
      // NOTE: the per-position digit registers are plain flops, not a RAM, so they reset to blank.
      digits_q <= '1;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign pattern_err = err_q;
  assign err_sticky  = sticky_q;

endmodule
